// File: rtl/sample_feeder_pkg.sv
// Shared constants for the sample feeder and the FIR datapath/control that
// consumes its output: default sizes and the handoff FSM state encoding.
package sample_feeder_pkg;

    // Default FIFO depth (power of two) and sample width (FIR input width).
    localparam int FEEDER_DEPTH = 8;
    localparam int FEEDER_WIDTH = 8;

    // Handoff FSM state encoding, kept as plain constants so older
    // Verilog-style control blocks can share the same values.
    typedef logic [1:0] feeder_state_t;

    localparam feeder_state_t ST_IDLE  = 2'd0;
    localparam feeder_state_t ST_ISSUE = 2'd1;
    localparam feeder_state_t ST_WAIT  = 2'd2;

endpackage : sample_feeder_pkg

// File: rtl/sync_fifo.sv
// Single-clock FIFO built on a register array. Pointers wrap modulo DEPTH
// (DEPTH is a power of two), and an explicit occupancy counter tells a
// full FIFO apart from an empty one.
module sync_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             do_push, do_pop;

    // Status flags and the accepted push/pop qualifiers.
    always_comb begin
        full    = (count_q == FULL_COUNT);
        empty   = (count_q == '0);
        do_push = push && !full;
        do_pop  = pop && !empty;
        dout    = mem_q[rd_ptr_q];
        count   = count_q;
    end

    // Pointer and occupancy next state; simultaneous push and pop leaves
    // the count unchanged.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Sample storage write port.
    // NOTE: the array is deliberately not reset; pointers and count define
    // which entries are live, so stale contents can never be delivered.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

    // Pointer and count registers with synchronous reset (flushes the FIFO).
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule : sync_fifo

// File: rtl/sample_feeder.sv
// Buffers upstream samples and hands them to the FIR one at a time: a
// single-cycle fir_en strobe per FIR busy period, gated by fir_ready.
// A push attempted while the FIFO is full is dropped and flagged on
// overflow in the following cycle.
module sample_feeder
    import sample_feeder_pkg::*;
#(
    parameter int DEPTH = FEEDER_DEPTH,
    parameter int WIDTH = FEEDER_WIDTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    input  logic [WIDTH-1:0]         in_data,
    output logic                     in_ready,
    input  logic                     fir_ready,
    output logic                     fir_en,
    output logic [WIDTH-1:0]         fir_x,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow
);

    feeder_state_t    state_q, state_d;
    logic [WIDTH-1:0] fir_x_q, fir_x_d;
    logic             overflow_q;
    logic             fifo_pop;
    logic             fifo_full;
    logic             fifo_empty;
    logic [WIDTH-1:0] fifo_dout;

    sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (WIDTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (in_valid),
        .pop   (fifo_pop),
        .din   (in_data),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (count)
    );

    // Handoff FSM: pop the head into fir_x when the FIR is ready, strobe for
    // one cycle, then wait for the FIR to drop fir_ready before re-arming.
    // NOTE: every combinational output gets a default first so no path
    // through the case statement can infer a latch.
    always_comb begin
        state_d  = state_q;
        fifo_pop = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty && fir_ready) begin
                    state_d  = ST_ISSUE;
                    fifo_pop = 1'b1;
                end
            end
            ST_ISSUE: state_d = ST_WAIT;
            ST_WAIT: begin
                if (!fir_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        fir_x_d = fifo_pop ? fifo_dout : fir_x_q;
    end

    // FSM state, output sample and overflow flag registers.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            fir_x_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            fir_x_q    <= fir_x_d;
            overflow_q <= in_valid && fifo_full;
        end
    end

    // Output decode; in_ready is combinational so a full FIFO refuses a push
    // even when a pop happens on the same edge.
    always_comb begin
        in_ready = !fifo_full;
        fir_en   = (state_q == ST_ISSUE);
        fir_x    = fir_x_q;
        overflow = overflow_q;
    end

endmodule : sample_feeder

// File: tb/tb_sample_feeder.sv
// Scoreboard bench for sample_feeder: the stimulus thread pushes expected
// samples into a queue as it drives them; a negedge monitor pops and
// compares on every fir_en strobe. An optional FIR model holds fir_ready low
// for 8 cycles after each strobe.
module tb_sample_feeder;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    logic       fir_ready;
    logic       fir_en;
    logic [7:0] fir_x;
    logic [3:0] count;
    logic       overflow;

    logic       man_ready;
    logic       model_ready = 1'b1;
    logic       fir_model_on;
    logic       mon_en = 1'b0;

    logic [7:0] exp_q [$];
    logic [7:0] mon_exp;
    int         checks = 0;
    int         failures = 0;
    int         strobe_cnt = 0;
    int         s0;

    assign fir_ready = fir_model_on ? model_ready : man_ready;

    sample_feeder #(.DEPTH(8), .WIDTH(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .fir_ready (fir_ready),
        .fir_en    (fir_en),
        .fir_x     (fir_x),
        .count     (count),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every strobe must match the oldest outstanding sample.
    always @(negedge clk) begin
        if (mon_en && fir_en === 1'b1) begin
            strobe_cnt++;
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_strobe fir_x=0x%0h required=no strobe", fir_x);
            end else begin
                mon_exp = exp_q.pop_front();
                check("fir_x_order", {24'h0, fir_x}, {24'h0, mon_exp});
            end
        end
    end

    // FIR model: busy (fir_ready low) for 8 cycles after each strobe.
    always @(negedge clk) begin
        if (fir_model_on && fir_en === 1'b1) begin
            model_ready = 1'b0;
            repeat (8) @(negedge clk);
            model_ready = 1'b1;
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drive(input logic [7:0] d, input bit accept);
        in_valid = 1'b1;
        in_data  = d;
        if (accept) exp_q.push_back(d);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic push_when_ready(input logic [7:0] d);
        for (int w = 0; w < 40 && !in_ready; w++) cyc(1);
        if (!in_ready) begin
            checks++;
            failures++;
            $display("FAIL in_ready_timeout sample=0x%0h actual=0 required=1", d);
        end else begin
            drive(d, 1'b1);
        end
    endtask

    task automatic wait_drain(input int max, input string name);
        for (int i = 0; i < max && exp_q.size() != 0; i++) cyc(1);
        check(name, exp_q.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1;
        in_valid = 1'b0;
        in_data = 8'h00;
        man_ready = 1'b0;
        fir_model_on = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state.
        check("rst_count", count, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_fir_en", fir_en, 0);
        check("rst_fir_x", fir_x, 0);
        check("rst_overflow", overflow, 0);
        mon_en = 1'b1;

        // Latency with fir_ready held high; single strobe only.
        man_ready = 1'b1;
        cyc(1);
        s0 = strobe_cnt;
        drive(8'hA5, 1'b1);
        check("lat_en_after_push_edge", fir_en, 0);
        check("lat_count_after_push", count, 1);
        cyc(1);
        check("lat_en_second_edge", fir_en, 1);
        check("lat_fir_x", fir_x, 8'hA5);
        check("lat_count_after_pop", count, 0);
        cyc(6);
        check("lat_single_strobe", strobe_cnt - s0, 1);
        check("lat_fir_x_hold", fir_x, 8'hA5);
        man_ready = 1'b0;
        cyc(2);

        // Three samples through the modelled FIR.
        fir_model_on = 1'b1;
        s0 = strobe_cnt;
        drive(8'h11, 1'b1);
        drive(8'h22, 1'b1);
        drive(8'h33, 1'b1);
        wait_drain(200, "three_drain");
        cyc(12);
        check("three_strobes", strobe_cnt - s0, 3);
        check("three_count_end", count, 0);
        fir_model_on = 1'b0;

        // Overflow: nine pushes with the FIR stalled.
        man_ready = 1'b0;
        for (int i = 1; i <= 8; i++) drive(8'(i), 1'b1);
        check("ovf_count_full", count, 8);
        check("ovf_in_ready_full", in_ready, 0);
        check("ovf_no_pulse_yet", overflow, 0);
        drive(8'h09, 1'b0);
        check("ovf_pulse", overflow, 1);
        check("ovf_count_held", count, 8);
        cyc(1);
        check("ovf_pulse_one_cycle", overflow, 0);
        fir_model_on = 1'b1;
        wait_drain(300, "ovf_drain");
        cyc(12);
        check("ovf_count_end", count, 0);
        fir_model_on = 1'b0;

        // Simultaneous push/pop at count 4, then 20 samples across the wrap.
        man_ready = 1'b0;
        for (int i = 0; i < 4; i++) drive(8'h40 + 8'(i), 1'b1);
        check("pp_count_before", count, 4);
        in_valid = 1'b1;
        in_data = 8'h44;
        exp_q.push_back(8'h44);
        fir_model_on = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("pp_count_same_cycle", count, 4);
        for (int i = 5; i < 20; i++) push_when_ready(8'h40 + 8'(i));
        wait_drain(600, "wrap_drain");
        cyc(12);
        check("wrap_count_end", count, 0);
        fir_model_on = 1'b0;

        // Reset during ISSUE with five samples still queued.
        man_ready = 1'b0;
        for (int i = 0; i < 6; i++) drive(8'h60 + 8'(i), 1'b1);
        check("mr_count_before", count, 6);
        man_ready = 1'b1;
        cyc(1);
        check("mr_in_issue", fir_en, 1);
        check("mr_count_issue", count, 5);
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
        exp_q.delete();
        check("mr_fir_en", fir_en, 0);
        check("mr_count", count, 0);
        check("mr_in_ready", in_ready, 1);
        check("mr_fir_x", fir_x, 0);
        check("mr_overflow", overflow, 0);
        s0 = strobe_cnt;
        cyc(10);
        check("mr_no_stale_strobe", strobe_cnt - s0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_sample_feeder

// File: doc/sample_feeder.md
SAMPLE_FEEDER -- requirements
Module: sample_feeder

Interface
REQ-001 Parameter DEPTH, default 8, sample FIFO depth (power of two, 2..64).
REQ-002 Parameter WIDTH, default 8, sample width in bits; matches the FIR input width.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 in_valid  input  1  upstream presents a sample this cycle.
REQ-006 in_data  input  WIDTH  upstream sample.
REQ-007 in_ready  output  1  FIFO not full; the sample is accepted when in_valid && in_ready.
REQ-008 fir_ready  input  1  FIR able to take a new sample.
REQ-009 fir_en  output  1  one-cycle strobe; fir_x is valid while it is high.
REQ-010 fir_x  output  WIDTH  sample handed to the FIR.
REQ-011 count  output  clog2(DEPTH)+1  current FIFO occupancy.
REQ-012 overflow  output  1  one-cycle pulse when in_valid is high while the FIFO is full; the sample is dropped.

Function
REQ-013 The FIFO is first-in first-out; samples reach fir_x in acceptance order, with no duplication and no loss except on overflow.
REQ-014 in_ready SHALL be combinational !full; a push is refused when full even if a pop occurs in the same cycle.
REQ-015 Push and pop in the same cycle SHALL leave count unchanged and store and deliver both samples correctly.
REQ-016 Read and write pointers SHALL wrap modulo DEPTH with no bubble at the wrap.
REQ-017 The FSM SHALL have three states: IDLE, ISSUE, WAIT.
REQ-018 IDLE -> ISSUE when count>0 && fir_ready; the head sample is popped into the fir_x register on that same edge.
REQ-019 ISSUE lasts exactly one cycle with fir_en=1; ISSUE -> WAIT unconditionally.
REQ-020 WAIT -> IDLE when fir_ready==0, which means the FIR has taken the sample; otherwise the FSM stays in WAIT indefinitely.
REQ-021 IDLE SHALL NOT issue again until fir_ready is high, which guarantees one strobe per FIR busy cycle.
REQ-022 fir_en SHALL be 0 in IDLE and WAIT.
REQ-023 fir_x SHALL hold its last value outside ISSUE.
REQ-024 Latency: for a sample pushed at edge N into an empty FIFO with FSM=IDLE and fir_ready=1, fir_en SHALL be high in the cycle after edge N+1.
REQ-025 With the FIFO empty, the FSM SHALL remain in IDLE and count SHALL be 0.
REQ-026 overflow SHALL be registered, high for exactly the cycle after the refused push, and never high when in_ready was 1.

Reset
REQ-027 On rst: FSM=IDLE, both pointers=0, count=0, fir_en=0, fir_x=0, overflow=0, all on the next edge.
REQ-028 rst asserted mid-operation, including during ISSUE or WAIT, SHALL flush the FIFO contents and drop the in-flight handoff; no fir_en SHALL appear in the cycle after the reset edge.
REQ-029 in_ready SHALL be 1 from the first cycle after reset.

Structure
REQ-030 A shared package/header SHALL hold the DEPTH and WIDTH defaults and the FSM state encoding (IDLE=2'd0, ISSUE=2'd1, WAIT=2'd2), for reuse by the FIR datapath and control.
REQ-031 Storage SHALL be one sub-module, sync_fifo (push, pop, din, dout, full, empty, count); the handoff FSM and the overflow flag SHALL live in sample_feeder.
REQ-032 The FIFO SHALL use a register array; no vendor RAM primitives.

Verification
REQ-033 Push 0x11, 0x22, 0x33 with fir_ready modelled as the FIR (low for 8 cycles after each en) -> exactly three fir_en pulses, with fir_x 0x11, 0x22, 0x33 in order.
REQ-034 Push 9 samples 0x01..0x09 back-to-back with fir_ready=0 -> count=8, in_ready=0 at the 9th, overflow pulses once, and 0x09 is never issued.
REQ-035 With fir_ready held 1, push 0xA5 into an empty FIFO -> fir_en is high exactly 2 cycles after the push edge with fir_x=0xA5, and no second strobe occurs while fir_ready stays 1.
REQ-036 At count=4, push and pop on the same cycle -> count stays 4; after 20 pushed samples with pointer wrap, the output order matches the input order.
REQ-037 Assert rst for 1 cycle while FSM=ISSUE with count=5 -> the next cycle shows fir_en=0, count=0, in_ready=1, fir_x=0, and no stale sample is later issued.
